// File: rtl/count_uart_reporter_if.sv
// count_uart_reporter_if: request/report bundle between a counter-side
// requester and the UART hex reporter.
// Signals: value[7:0] and send (requester -> reporter); busy, done and tx
// (reporter -> requester / pin). master = requester, slave = reporter.
interface count_uart_reporter_if;
  logic [7:0] value;
  logic       send;
  logic       busy;
  logic       done;
  logic       tx;

  modport master (
    output value,
    output send,
    input  busy,
    input  done,
    input  tx
  );

  modport slave (
    input  value,
    input  send,
    output busy,
    output done,
    output tx
  );
endinterface

// File: rtl/count_uart_reporter.sv
// count_uart_reporter: on a one-cycle send request, snapshots an 8-bit counter
// value and transmits it as two upper-case hex ASCII characters, UART 8N1.
// Ports: clk, rst (sync, active-high), bus (slave modport): value, send in;
//        busy, done, tx out (all registered; tx idles high).
// Latency: tx drops to the start bit at the accepting edge; busy lasts exactly
//   N*10*CLKS_PER_BIT cycles, then done pulses for one cycle.
// Backpressure: none; send while busy is dropped, there is no queueing.
// Option: define CRLF_EN to append 0x0D 0x0A after the two digits (N=4);
//   left undefined, N=2 and no CR/LF logic exists.
module count_uart_reporter #(
  parameter int CLKS_PER_BIT = 104
) (
  input  logic                   clk,
  input  logic                   rst,
  count_uart_reporter_if.slave   bus
);

  // Baud counter only needs to reach CLKS_PER_BIT-1.
  localparam int BW = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [BW-1:0] BAUD_LAST = BW'(CLKS_PER_BIT - 1);
  localparam logic [BW-1:0] BAUD_ONE  = BW'(1);

`ifdef CRLF_EN
  localparam logic [1:0] LAST_CHAR = 2'd3;
`else
  localparam logic [1:0] LAST_CHAR = 2'd1;
`endif

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } state_t;

  state_t         state;
  logic [BW-1:0]  baud;
  logic [2:0]     bit_idx;
  logic [1:0]     char_idx;
  logic [7:0]     snap;
  logic [7:0]     shreg;
  logic           tx_q;
  logic           busy_q;
  logic           done_q;
  logic [7:0]     next_char;

  // Nibble to upper-case ASCII hex: 0-9 -> '0'..'9', A-F -> 'A'..'F'.
  function automatic logic [7:0] hex_ascii(input logic [3:0] nib);
    if (nib < 4'd10)
      return 8'h30 + {4'h0, nib};
    else
      return 8'h37 + {4'h0, nib};
  endfunction

  // Character to transmit for a given position in the report.
  function automatic logic [7:0] char_at(input logic [1:0] idx,
                                         input logic [7:0] v);
    logic [7:0] c;
    case (idx)
      2'd0:    c = hex_ascii(v[7:4]);
      2'd1:    c = hex_ascii(v[3:0]);
`ifdef CRLF_EN
      2'd2:    c = 8'h0D;
      2'd3:    c = 8'h0A;
`endif
      default: c = 8'h00;
    endcase
    return c;
  endfunction

  assign next_char = char_at(char_idx, snap);

  assign bus.tx   = tx_q;
  assign bus.busy = busy_q;
  assign bus.done = done_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      baud     <= '0;
      bit_idx  <= '0;
      char_idx <= '0;
      snap     <= '0;
      shreg    <= '0;
      tx_q     <= 1'b1;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state)
        IDLE: begin
          tx_q <= 1'b1;
          // busy is low exactly while in IDLE, so this is the accept rule.
          if (bus.send) begin
            snap     <= bus.value;
            char_idx <= '0;
            baud     <= '0;
            state    <= START;
            busy_q   <= 1'b1;
            tx_q     <= 1'b0;
          end
        end

        START: begin
          if (baud == BAUD_LAST) begin
            // Load the character here so the snapshot only needs to be
            // decoded once per character.
            baud    <= '0;
            bit_idx <= '0;
            shreg   <= next_char;
            tx_q    <= next_char[0];
            state   <= DATA;
          end else begin
            baud <= baud + BAUD_ONE;
          end
        end

        DATA: begin
          if (baud == BAUD_LAST) begin
            baud <= '0;
            if (bit_idx == 3'd7) begin
              tx_q  <= 1'b1;
              state <= STOP;
            end else begin
              // shreg[0] is the bit currently on the line; advance LSB first.
              bit_idx <= bit_idx + 3'd1;
              shreg   <= {1'b0, shreg[7:1]};
              tx_q    <= shreg[1];
            end
          end else begin
            baud <= baud + BAUD_ONE;
          end
        end

        STOP: begin
          if (baud == BAUD_LAST) begin
            baud <= '0;
            if (char_idx == LAST_CHAR) begin
              state  <= IDLE;
              busy_q <= 1'b0;
              done_q <= 1'b1;
              tx_q   <= 1'b1;
            end else begin
              // Back-to-back: next start bit follows the stop bit directly.
              char_idx <= char_idx + 2'd1;
              state    <= START;
              tx_q     <= 1'b0;
            end
          end else begin
            baud <= baud + BAUD_ONE;
          end
        end

        default: begin
          state  <= IDLE;
          busy_q <= 1'b0;
          tx_q   <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_count_uart_reporter.sv
// tb_count_uart_reporter: self-checking bench for count_uart_reporter with
// CLKS_PER_BIT=4. Table-driven report vectors, hand-written corner sequences
// and a randomized run compared cycle by cycle against a waveform model.
module tb_count_uart_reporter;

  localparam int CPB = 4;
`ifdef CRLF_EN
  localparam int NCH = 4;
`else
  localparam int NCH = 2;
`endif
  localparam int L = NCH * 10 * CPB;

  logic clk = 1'b0;
  logic rst;

  count_uart_reporter_if bus ();

  count_uart_reporter #(.CLKS_PER_BIT(CPB)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  typedef logic [7:0] byteq_t[$];

  int total = 0;
  int bad   = 0;

  // Reference model: a report is just a list of tx levels, one per busy cycle.
  logic m_busy, m_done, m_tx;
  logic mq[$];

  // Observations from the DUT.
  logic tr[$];
  int   busy_cnt;
  int   done_cnt;

  string hexdig = "0123456789ABCDEF";

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic byteq_t report_chars(input logic [7:0] v);
    byteq_t q;
    q.push_back(hexdig[v[7:4]]);
    q.push_back(hexdig[v[3:0]]);
`ifdef CRLF_EN
    q.push_back(8'h0D);
    q.push_back(8'h0A);
`endif
    return q;
  endfunction

  function automatic void model_update(input logic s, input logic [7:0] v,
                                       input logic r);
    byteq_t cs;
    if (r) begin
      m_busy = 1'b0; m_done = 1'b0; m_tx = 1'b1;
      mq.delete();
    end else if (m_busy) begin
      m_done = 1'b0;
      if (mq.size() == 0) begin
        m_busy = 1'b0; m_done = 1'b1; m_tx = 1'b1;
      end else begin
        m_tx = mq.pop_front();
      end
    end else begin
      m_done = 1'b0;
      m_tx   = 1'b1;
      if (s) begin
        cs = report_chars(v);
        foreach (cs[k]) begin
          for (int n = 0; n < CPB; n++) mq.push_back(1'b0);
          for (int b = 0; b < 8; b++)
            for (int n = 0; n < CPB; n++) mq.push_back(cs[k][b]);
          for (int n = 0; n < CPB; n++) mq.push_back(1'b1);
        end
        m_busy = 1'b1;
        m_tx   = mq.pop_front();
      end
    end
  endfunction

  // One clock: drive inputs, take the edge, advance the model, compare at +1.
  task automatic step(input logic s, input logic [7:0] v, input logic r);
    bus.send  = s;
    bus.value = v;
    rst       = r;
    @(posedge clk);
    model_update(s, v, r);
    #1;
    check("busy", {31'd0, bus.busy}, {31'd0, m_busy});
    check("done", {31'd0, bus.done}, {31'd0, m_done});
    check("tx",   {31'd0, bus.tx},   {31'd0, m_tx});
    if (bus.busy) begin
      tr.push_back(bus.tx);
      busy_cnt++;
    end
    if (bus.done) done_cnt++;
  endtask

  // Decode the recorded busy-period tx trace as 8N1 at bit centres.
  task automatic check_decode(input string tag, input byteq_t exp);
    int base;
    logic [7:0] c;
    foreach (exp[k]) begin
      base = k * 10 * CPB + CPB / 2;
      if (base + 9 * CPB >= tr.size()) begin
        check({tag, "_trace_len"}, tr.size(), base + 9 * CPB + 1);
      end else begin
        for (int b = 0; b < 8; b++) c[b] = tr[base + (b + 1) * CPB];
        check({tag, "_start"}, {31'd0, tr[base]}, 32'd0);
        check({tag, "_char"}, {24'd0, c}, {24'd0, exp[k]});
        check({tag, "_stop"}, {31'd0, tr[base + 9 * CPB]}, 32'd1);
      end
    end
  endtask

  task automatic run_report(input logic [7:0] v, output int done_at);
    tr.delete();
    busy_cnt = 0;
    done_cnt = 0;
    done_at  = -1;
    step(1'b1, v, 1'b0);
    for (int i = 1; i <= L + 20; i++) begin
      step(1'b0, ~v, 1'b0);
      if (bus.done && done_at < 0) done_at = i;
    end
  endtask

  typedef struct {
    logic [7:0] value;
    logic [7:0] hi;
    logic [7:0] lo;
  } vec_t;

  vec_t vecs[8];

  initial begin
    int     done_at;
    byteq_t exp;
    logic   prev_busy;
    int     low_run, rises;
    bit     seen;

    vecs[0] = '{8'h3A, "3", "A"};
    vecs[1] = '{8'h00, "0", "0"};
    vecs[2] = '{8'h9A, "9", "A"};
    vecs[3] = '{8'hFF, "F", "F"};
    vecs[4] = '{8'h5C, "5", "C"};
    vecs[5] = '{8'h09, "0", "9"};
    vecs[6] = '{8'hA0, "A", "0"};
    vecs[7] = '{8'hB7, "B", "7"};

    busy_cnt = 0;
    done_cnt = 0;

    // Reset state.
    step(1'b0, 8'h00, 1'b1);
    step(1'b1, 8'h55, 1'b1);
    check("rst_tx",   {31'd0, bus.tx},   32'd1);
    check("rst_busy", {31'd0, bus.busy}, 32'd0);
    check("rst_done", {31'd0, bus.done}, 32'd0);
    step(1'b0, 8'h00, 1'b0);

    // Table of single reports, each started after the previous completes.
    for (int t = 0; t < 8; t++) begin
      exp.delete();
      exp.push_back(vecs[t].hi);
      exp.push_back(vecs[t].lo);
`ifdef CRLF_EN
      exp.push_back(8'h0D);
      exp.push_back(8'h0A);
`endif
      run_report(vecs[t].value, done_at);
      check("vec_busy_len", busy_cnt, L);
      check("vec_done_cnt", done_cnt, 1);
      check("vec_done_at",  done_at,  L);
      check("vec_tx_idle",  {31'd0, bus.tx}, 32'd1);
      check_decode("vec", exp);
    end

    // Snapshot holds and re-requests while busy (including the completion
    // edge) are dropped.
    tr.delete(); busy_cnt = 0; done_cnt = 0;
    step(1'b1, 8'h12, 1'b0);
    for (int i = 1; i <= L + 20; i++)
      step((i == 10 || i == 40 || i == L), 8'h34, 1'b0);
    check("drop_done_cnt", done_cnt, 1);
    check("drop_busy_len", busy_cnt, L);
    exp.delete();
    exp.push_back("1");
    exp.push_back("2");
`ifdef CRLF_EN
    exp.push_back(8'h0D);
    exp.push_back(8'h0A);
`endif
    check_decode("drop", exp);

    // Reset in the middle of a report.
    tr.delete(); busy_cnt = 0; done_cnt = 0;
    step(1'b1, 8'hC3, 1'b0);
    for (int i = 1; i < 25; i++) step(1'b0, 8'hC3, 1'b0);
    step(1'b0, 8'hC3, 1'b1);
    check("midrst_tx",   {31'd0, bus.tx},   32'd1);
    check("midrst_busy", {31'd0, bus.busy}, 32'd0);
    for (int i = 0; i < 2 * L; i++) step(1'b0, 8'hC3, 1'b0);
    check("midrst_no_done", done_cnt, 0);
    exp = report_chars(8'h5C);
    run_report(8'h5C, done_at);
    check("after_rst_done_at", done_at, L);
    check_decode("after_rst", exp);

    // send held high: reports separated by exactly one idle cycle.
    prev_busy = bus.busy; low_run = 0; rises = 0; seen = 1'b0;
    for (int i = 0; i < 300; i++) begin
      step(1'b1, 8'($urandom), 1'b0);
      if (bus.busy && !prev_busy) begin
        if (seen) check("held_gap", low_run, 1);
        rises++;
        seen = 1'b1;
      end
      if (!bus.busy) low_run++;
      else low_run = 0;
      prev_busy = bus.busy;
    end
    check("held_reports", rises, (300 - 1) / (L + 1) + 1);
    for (int i = 0; i < L + 5; i++) step(1'b0, 8'h00, 1'b0);

    // Randomized traffic with occasional resets, checked against the model.
    for (int i = 0; i < 3000; i++)
      step(($urandom_range(0, 9) == 0), 8'($urandom),
           ($urandom_range(0, 399) == 0));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
